// File: rtl/memory_controller_pkg.sv
// Shared constants and types for the SIMD-core memory arbiter.
// One batch services every core index in order, one index per clock.
package memory_controller_pkg;

    localparam int N_CORES    = 4;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int CLK_PERIOD = 10;

    // Guard keeps the index at least one bit wide for a single-core build.
    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SERVICE = 1'b1;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/memory_controller.sv
// Serialises per-core read/write requests onto a single-port DataMemory that is clocked on ~clk.
// A request pulse snapshots all lanes; each lane then gets exactly one cycle, enabled or not.
module memory_controller
    import memory_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              MRead,
    input  logic              MWrite,
    output logic              MReady,
    input  logic [N_CORES-1:0] en,
    input  logic [ADDR_W-1:0] addr [N_CORES],
    input  logic [DATA_W-1:0] data [N_CORES],
    output logic [DATA_W-1:0] q [N_CORES],
    output logic [DATA_W-1:0] data_to_mem,
    output logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] data_from_mem,
    output logic              wren
);

    logic [0:0]         state_reg;
    logic [IDX_W-1:0]   idx_reg;
    op_t                op_reg;
    logic [N_CORES-1:0] en_reg;
    logic               ready_reg;
    logic [ADDR_W-1:0]  addr_reg [N_CORES];
    logic [DATA_W-1:0]  data_reg [N_CORES];
    logic [DATA_W-1:0]  q_reg [N_CORES];

    logic in_service;
    logic start;
    logic last_idx;

    assign in_service = (state_reg == ST_SERVICE);
    assign start      = !in_service && (MRead || MWrite);
    assign last_idx   = (idx_reg == IDX_W'(N_CORES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            op_reg    <= OP_READ;
            en_reg    <= '0;
            ready_reg <= 1'b1;
        end else if (start) begin
            state_reg <= ST_SERVICE;
            idx_reg   <= '0;
            op_reg    <= MWrite ? OP_WRITE : OP_READ;
            en_reg    <= en;
            ready_reg <= 1'b0;
        end else if (in_service) begin
            if (last_idx) begin
                state_reg <= ST_IDLE;
                idx_reg   <= '0;
                ready_reg <= 1'b1;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Per-lane snapshot and read-result registers; a lane's q only moves in its own read slot.
    genvar gi;
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_lane
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    addr_reg[gi] <= '0;
                    data_reg[gi] <= '0;
                    q_reg[gi]    <= '0;
                end else begin
                    if (start) begin
                        addr_reg[gi] <= addr[gi];
                        data_reg[gi] <= data[gi];
                    end
                    if (in_service && (op_reg == OP_READ) && en_reg[gi]
                        && (idx_reg == IDX_W'(gi))) begin
                        q_reg[gi] <= data_from_mem;
                    end
                end
            end
            assign q[gi] = q_reg[gi];
        end
    endgenerate

    // Decoded from registered state so the memory sees settled values at the falling edge.
    always_comb begin
        wren        = 1'b0;
        addr_mem    = '0;
        data_to_mem = '0;
        if (in_service) begin
            addr_mem    = addr_reg[idx_reg];
            data_to_mem = data_reg[idx_reg];
            wren        = (op_reg == OP_WRITE) && en_reg[idx_reg];
        end
    end

    assign MReady = ready_reg;

endmodule

// File: tb/tb_memory_controller.sv
// Bench: memory_controller plus a small DataMemory on ~clk, checked against a lane-by-lane
// behavioural model of batch reads and writes.
module tb_memory_controller;
    import memory_controller_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               MRead = 1'b0;
    logic               MWrite = 1'b0;
    logic               MReady;
    logic [N_CORES-1:0] en = '0;
    logic [ADDR_W-1:0]  addr [N_CORES];
    logic [DATA_W-1:0]  data [N_CORES];
    logic [DATA_W-1:0]  q [N_CORES];
    logic [DATA_W-1:0]  data_to_mem;
    logic [ADDR_W-1:0]  addr_mem;
    logic [DATA_W-1:0]  data_from_mem;
    logic               wren;

    // DataMemory stand-in: 256 words, sampled on the falling clk edge, plus a preload port.
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] mem_q = '0;
    logic              pre_we = 1'b0;
    logic [7:0]        pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] ref_q [N_CORES];

    int n_checks = 0;
    int n_errors = 0;

    memory_controller dut (
        .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite), .MReady(MReady),
        .en(en), .addr(addr), .data(data), .q(q),
        .data_to_mem(data_to_mem), .addr_mem(addr_mem),
        .data_from_mem(data_from_mem), .wren(wren)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    always @(negedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (wren) mem[addr_mem[7:0]] <= data_to_mem;
        mem_q <= mem[addr_mem[7:0]];
    end
    assign data_from_mem = mem_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        ref_mem[a] = d;
        @(negedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic set_stim(input logic [N_CORES-1:0] e,
                            input int a0, input int a1, input int a2, input int a3,
                            input int d0, input int d1, input int d2, input int d3);
        en = e;
        addr[0] = ADDR_W'(a0); addr[1] = ADDR_W'(a1);
        addr[2] = ADDR_W'(a2); addr[3] = ADDR_W'(a3);
        data[0] = DATA_W'(d0); data[1] = DATA_W'(d1);
        data[2] = DATA_W'(d2); data[3] = DATA_W'(d3);
    endtask

    task automatic check_q(input string tag);
        for (int i = 0; i < N_CORES; i++)
            check($sformatf("%s_q%0d", tag, i), 32'(q[i]), 32'(ref_q[i]));
    endtask

    // Called just after a rising edge; drives the request, walks the batch, updates the model.
    task automatic run_batch(input logic rd, input logic wr, input bit pulse_mid, input string name);
        logic [N_CORES-1:0] e_l;
        logic [ADDR_W-1:0]  a_l [N_CORES];
        logic [DATA_W-1:0]  d_l [N_CORES];
        e_l = en;
        a_l = addr;
        d_l = data;
        MRead  = rd;
        MWrite = wr;
        @(posedge clk); #1;
        MRead  = 1'b0;
        MWrite = 1'b0;
        // Inputs wander mid-batch; the snapshot must be what gets used.
        en = N_CORES'($urandom);
        for (int i = 0; i < N_CORES; i++) begin
            addr[i] = ADDR_W'($urandom_range(0, 255));
            data[i] = DATA_W'($urandom);
        end
        for (int k = 0; k < N_CORES; k++) begin
            check($sformatf("%s_busy%0d", name, k), 32'(MReady), 32'd0);
            check($sformatf("%s_wren%0d", name, k), 32'(wren), 32'(wr & e_l[k]));
            check($sformatf("%s_addr%0d", name, k), 32'(addr_mem), 32'(a_l[k]));
            if (wr) check($sformatf("%s_wdata%0d", name, k), 32'(data_to_mem), 32'(d_l[k]));
            if (pulse_mid && k == 1) MRead = 1'b1;
            @(posedge clk); #1;
            MRead = 1'b0;
        end
        check($sformatf("%s_ready", name), 32'(MReady), 32'd1);
        for (int i = 0; i < N_CORES; i++) begin
            if (e_l[i]) begin
                if (wr) ref_mem[a_l[i][7:0]] = d_l[i];
                else    ref_q[i] = ref_mem[a_l[i][7:0]];
            end
        end
        check_q(name);
        if (wr) begin
            for (int i = 0; i < N_CORES; i++)
                if (e_l[i])
                    check($sformatf("%s_mem%0d", name, i), 32'(mem[a_l[i][7:0]]),
                          32'(ref_mem[a_l[i][7:0]]));
        end
        if (pulse_mid) begin
            for (int k = 0; k < 2; k++) begin
                @(posedge clk); #1;
                check($sformatf("%s_noretrig%0d", name, k), 32'(MReady), 32'd1);
            end
        end
        $display("batch %s rd=%0b wr=%0b en=%b a={%0d,%0d,%0d,%0d} q={%0h,%0h,%0h,%0h}",
                 name, rd, wr, e_l, a_l[0], a_l[1], a_l[2], a_l[3], q[0], q[1], q[2], q[3]);
    endtask

    initial begin
        #(CLK_PERIOD * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_CORES; i++) begin
            addr[i]  = '0;
            data[i]  = '0;
            ref_q[i] = '0;
        end
        // Memory preload happens under reset, so the controller is quiet throughout.
        for (int i = 0; i < 256; i++) preload(8'(i), DATA_W'($urandom));
        preload(8'd11, 16'h0042);
        @(posedge clk); #1;
        check("rst_ready", 32'(MReady), 32'd1);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_addr_mem", 32'(addr_mem), 32'd0);
        check("rst_data_to_mem", 32'(data_to_mem), 32'd0);
        check_q("rst");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready", 32'(MReady), 32'd1);
        check("idle_wren", 32'(wren), 32'd0);
        check_q("idle");

        set_stim(4'b0010, 10, 11, 12, 13, 0, 0, 0, 0);
        run_batch(1'b1, 1'b0, 1'b0, "read_one");
        check("read_one_q1_const", 32'(q[1]), 32'h0042);

        set_stim(4'b1111, 20, 21, 22, 23, 9, 20, 55, 24);
        run_batch(1'b0, 1'b1, 1'b0, "write_all");
        set_stim(4'b1111, 20, 21, 22, 23, 0, 0, 0, 0);
        run_batch(1'b1, 1'b0, 1'b0, "readback");
        check("readback_q2_const", 32'(q[2]), 32'd55);

        set_stim(4'b0000, 20, 21, 22, 23, 1, 2, 3, 4);
        run_batch(1'b0, 1'b1, 1'b0, "write_none");
        check("write_none_mem20", 32'(mem[20]), 32'd9);
        check("write_none_mem23", 32'(mem[23]), 32'd24);

        set_stim(4'b1011, 30, 31, 32, 33, 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
        run_batch(1'b1, 1'b1, 1'b0, "both");

        set_stim(4'b1111, 30, 31, 32, 33, 0, 0, 0, 0);
        run_batch(1'b1, 1'b0, 1'b1, "busy_pulse");

        for (int n = 0; n < 24; n++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            en = N_CORES'($urandom);
            for (int i = 0; i < N_CORES; i++) begin
                addr[i] = ADDR_W'($urandom_range(0, 15));
                data[i] = DATA_W'($urandom);
            end
            case (mode)
                0: run_batch(1'b1, 1'b0, 1'b0, $sformatf("rnd%0d_rd", n));
                1: run_batch(1'b0, 1'b1, 1'b0, $sformatf("rnd%0d_wr", n));
                2: run_batch(1'b1, 1'b1, 1'b0, $sformatf("rnd%0d_both", n));
                default: begin
                    @(posedge clk); #1;
                    check($sformatf("rnd%0d_idle_ready", n), 32'(MReady), 32'd1);
                    check($sformatf("rnd%0d_idle_wren", n), 32'(wren), 32'd0);
                    $display("batch rnd%0d_idle no request", n);
                end
            endcase
        end

        // Abort a write batch while lane 2 is being serviced.
        set_stim(4'b1111, 20, 21, 22, 23, 16'h0111, 16'h0222, 16'h0333, 16'h0444);
        MWrite = 1'b1;
        @(posedge clk); #1;
        MWrite = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_pre_wren", 32'(wren), 32'd1);
        check("abort_pre_addr", 32'(addr_mem), 32'd22);
        reset = 1'b0;
        #1;
        check("abort_wren", 32'(wren), 32'd0);
        check("abort_ready", 32'(MReady), 32'd1);
        ref_mem[20] = 16'h0111;
        ref_mem[21] = 16'h0222;
        for (int i = 0; i < N_CORES; i++) ref_q[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_after_ready", 32'(MReady), 32'd1);
        check("abort_after_wren", 32'(wren), 32'd0);
        for (int a = 20; a < 24; a++)
            check($sformatf("abort_mem%0d", a), 32'(mem[a]), 32'(ref_mem[a]));
        check_q("abort");
        $display("batch abort_write reset at idx 2 mem={%0h,%0h,%0h,%0h}",
                 mem[20], mem[21], mem[22], mem[23]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
